grf_wb_arbiter: RTL

- Shares the single GRF write port (A3/WD/PC) between two sources:
  - the pipeline W stage, port A: highest priority, never back-pressured;
  - the long-latency unit (MDU result / CP0 loader), port B: valid/ready handshake, buffered in a FIFO.
- Drains the FIFO into idle write slots.
- Exports a per-register busy mask so D-stage hazard logic can stall readers and writers of pending registers.
- Requests a pipeline stall when port B starves.

---
 rtl/grf_wb_arbiter_if.sv | 35 +++
 rtl/grf_wb_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle between the GRF write-back arbiter and its sources: pipeline W port A,
// long-latency port B handshake, the shared GRF write port and the D-stage status signals.
interface grf_wb_arbiter_if;
  logic        a_we;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic [31:0] a_pc;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [31:0] b_pc;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [31:0] busy;
  logic        stall_req;
  logic        conflict;

  modport master (
    output a_we, a_addr, a_data, a_pc,
    output b_valid, b_addr, b_data, b_pc,
    input  b_ready,
    input  grf_a3, grf_wd, grf_pc,
    input  busy, stall_req, conflict
  );

  modport slave (
    input  a_we, a_addr, a_data, a_pc,
    input  b_valid, b_addr, b_data, b_pc,
    output b_ready,
    output grf_a3, grf_wd, grf_pc,
    output busy, stall_req, conflict
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: pipeline port A wins every slot, port B is queued and drained into idle slots.
// Optional macro GRF_WB_BYPASS_EN lets port B write straight through when the queue is empty and the slot idle.
module grf_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  grf_wb_arbiter_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int SW = 8;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == '1) ? v : SW'(v + 1'b1);
  endfunction

  logic [4:0]    q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic [OW-1:0] cnt [32];
  logic [SW-1:0] starve;
  logic [SW-1:0] starve_nxt;
  logic          stall_q, conflict_q;

  logic          empty, full, a_act, pop, accept, push, byp;
  logic [31:0]   inc_vec, dec_vec, busy_w;

  // Slot decision: A owns the slot when active, otherwise the queue head drains.
  assign empty  = (occ == '0);
  assign full   = (occ == OW'(DEPTH));
  assign a_act  = bus.a_we && (bus.a_addr != 5'd0);
  assign pop    = !a_act && !empty;
  // Readiness comes from registered occupancy only, so a full queue refuses even while draining.
  assign accept = bus.b_valid && !full;
`ifdef GRF_WB_BYPASS_EN
  assign byp    = empty && !a_act && bus.b_valid && (bus.b_addr != 5'd0);
`else
  assign byp    = 1'b0;
`endif
  assign push   = accept && (bus.b_addr != 5'd0) && !byp;

  assign bus.b_ready = reset && !full;

  always_comb begin
    bus.grf_a3 = '0;
    bus.grf_wd = '0;
    bus.grf_pc = '0;
    if (reset) begin
      if (a_act) begin
        bus.grf_a3 = bus.a_addr;
        bus.grf_wd = bus.a_data;
        bus.grf_pc = bus.a_pc;
      end else if (!empty) begin
        bus.grf_a3 = q_addr[rd_ptr];
        bus.grf_wd = q_data[rd_ptr];
        bus.grf_pc = q_pc[rd_ptr];
      end else if (byp) begin
        bus.grf_a3 = bus.b_addr;
        bus.grf_wd = bus.b_data;
        bus.grf_pc = bus.b_pc;
      end
    end
  end

  // Queue storage: payload registers carry no reset; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.b_addr;
      q_data[wr_ptr] <= bus.b_data;
      q_pc[wr_ptr]   <= bus.b_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= PW'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PW'(rd_ptr + 1'b1);
      occ <= OW'(occ + OW'(push) - OW'(pop));
    end
  end

  // Per-register pending counts; a push and pop of the same register cancel.
  assign inc_vec = push ? (32'd1 << bus.b_addr) : 32'd0;
  assign dec_vec = pop  ? (32'd1 << q_addr[rd_ptr]) : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r])      cnt[r] <= OW'(cnt[r] + 1'b1);
        else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= OW'(cnt[r] - 1'b1);
      end
    end
  end

  always_comb begin
    busy_w = '0;
    for (int r = 1; r < 32; r++) busy_w[r] = (cnt[r] != '0);
  end

  assign bus.busy = busy_w;

  // Starvation watchdog and sticky hazard flag.
  assign starve_nxt = sat_inc(starve);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve     <= '0;
      stall_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      if (pop || empty) starve <= '0;
      else              starve <= starve_nxt;
      if (pop)                                             stall_q <= 1'b0;
      else if (!empty && starve_nxt == SW'(STARVE_LIMIT))  stall_q <= 1'b1;
      if (a_act && busy_w[bus.a_addr]) conflict_q <= 1'b1;
    end
  end

  assign bus.stall_req = stall_q;
  assign bus.conflict  = conflict_q;
endmodule
